// File: rtl/order_pkg.sv
// Shared encodings for the order decode/operand-fetch stage: mode codes,
// well-known register indices, y2 selector codes and small decode helpers.
package order_pkg;

  localparam int ORDER_W = 32;

  typedef enum logic [4:0] {
    MODE_NOP       = 5'd0,
    MODE_ALU_FIRST = 5'd1,
    MODE_ALU_LAST  = 5'd6,
    MODE_LOAD      = 5'd7,
    MODE_STACK     = 5'd8,
    MODE_MOVE      = 5'd9,
    MODE_CJMP      = 5'd10,
    MODE_TEST      = 5'd17,
    MODE_XFER      = 5'd18
  } mode_e;

  typedef enum logic [3:0] {
    REG_NONE = 4'd0,
    REG_FLAG = 4'd9,
    REG_PC   = 4'd10,
    REG_TPC  = 4'd11,
    REG_SP   = 4'd13
  } reg_idx_e;

  typedef enum logic [1:0] {
    Y2_NONE = 2'd0,
    Y2_FLAG = 2'd1,
    Y2_SP   = 2'd2
  } y2_sel_e;

  // Modes the stage understands; anything else decodes to a NOP bundle.
  function automatic logic mode_is_legal(input logic [4:0] m);
    return ((m >= MODE_ALU_FIRST) && (m <= MODE_CJMP)) ||
           (m == MODE_TEST) || (m == MODE_XFER);
  endfunction

  // Only the low mode block carries a meaningful read/write bit.
  function automatic logic mode_has_rw(input logic [4:0] m);
    return (m >= MODE_ALU_FIRST) && (m <= MODE_CJMP);
  endfunction

  // Arithmetic-style modes that write a result register from x1ch.
  function automatic logic mode_is_alu(input logic [4:0] m);
    return (m >= MODE_ALU_FIRST) && (m <= MODE_ALU_LAST);
  endfunction

endpackage

// File: rtl/order_operand_sel.sv
// One operand channel: picks the newest value for a register index from the
// forwarding ports (lowest port wins) or the register file, and flags a RAW
// hazard when the register is still pending and nothing forwards it.
module order_operand_sel
  import order_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int REG_CNT   = 16,
  parameter int IDX_W     = $clog2(REG_CNT),
  parameter int FWD_PORTS = 2
) (
  input  logic [IDX_W-1:0]            ch_i,
  input  logic [REG_CNT*DATA_W-1:0]   rf_flat_i,
  input  logic [REG_CNT-1:0]          busy_i,
  input  logic [FWD_PORTS-1:0]        fwd_valid_i,
  input  logic [FWD_PORTS*IDX_W-1:0]  fwd_idx_i,
  input  logic [FWD_PORTS*DATA_W-1:0] fwd_data_i,
  output logic [DATA_W-1:0]           data_o,
  output logic                        hazard_o
);

  logic fwd_hit;

  // Walk ports from highest to lowest so the lowest matching port is the last write.
  always_comb begin
    data_o   = '0;
    fwd_hit  = 1'b0;
    if (ch_i != '0) begin
      data_o = rf_flat_i[int'(ch_i)*DATA_W +: DATA_W];
    end
    for (int p = FWD_PORTS - 1; p >= 0; p--) begin
      if (fwd_valid_i[p] && (ch_i != '0) && (fwd_idx_i[p*IDX_W +: IDX_W] == ch_i)) begin
        data_o  = fwd_data_i[p*DATA_W +: DATA_W];
        fwd_hit = 1'b1;
      end
    end
    hazard_o = (ch_i != '0) && busy_i[ch_i] && !fwd_hit;
  end

endmodule

// File: rtl/order_decode_pipe.sv
// Decode/operand-fetch stage between order fetch and execute. Decodes the
// order, fetches x1/x2 with forwarding, stalls on pending registers tracked
// by a busy-bit scoreboard and hands a registered bundle to execute.
module order_decode_pipe
  import order_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int REG_CNT   = 16,
  parameter int IDX_W     = $clog2(REG_CNT),
  parameter int FWD_PORTS = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [ORDER_W-1:0]          order,
  input  logic [DATA_W-1:0]           in_addr,
  input  logic                        in_irq,
  input  logic [7:0]                  in_irq_num,
  input  logic [REG_CNT*DATA_W-1:0]   rf_flat,
  input  logic [FWD_PORTS-1:0]        fwd_valid,
  input  logic [FWD_PORTS*IDX_W-1:0]  fwd_idx,
  input  logic [FWD_PORTS*DATA_W-1:0] fwd_data,
  input  logic                        wb_valid,
  input  logic [IDX_W-1:0]            wb_idx,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [4:0]                  mode,
  output logic                        rw,
  output logic [1:0]                  sub_mode,
  output logic [DATA_W-1:0]           x1,
  output logic [DATA_W-1:0]           x2,
  output logic [IDX_W-1:0]            y1_sel,
  output logic [1:0]                  y2_sel,
  output logic [DATA_W-1:0]           out_addr,
  output logic                        out_irq,
  output logic [7:0]                  out_irq_num
);

  logic [4:0]         dec_mode;
  logic               dec_rw;
  logic [1:0]         dec_sub;
  logic [IDX_W-1:0]   dec_x1ch;
  logic [IDX_W-1:0]   dec_x2ch;
  logic [15:0]        dec_imm;
  logic [IDX_W-1:0]   dec_y1;
  logic [1:0]         dec_y2;

  logic [DATA_W-1:0]  x1_src;
  logic [DATA_W-1:0]  x2_src;
  logic               x1_haz;
  logic               x2_haz;
  logic               stall;
  logic               accept;

  logic [REG_CNT-1:0] busy_q;
  logic [REG_CNT-1:0] busy_d;

  logic               out_valid_q;
  logic [4:0]         mode_q;
  logic               rw_q;
  logic [1:0]         sub_q;
  logic [DATA_W-1:0]  x1_q;
  logic [DATA_W-1:0]  x2_q;
  logic [IDX_W-1:0]   y1_q;
  logic [1:0]         y2_q;
  logic [DATA_W-1:0]  addr_q;
  logic               irq_q;
  logic [7:0]         irq_num_q;

  // Field extraction; illegal modes collapse to an all-zero NOP so they touch no registers.
  always_comb begin
    dec_mode = '0;
    dec_rw   = 1'b0;
    dec_sub  = '0;
    dec_x1ch = '0;
    dec_x2ch = '0;
    dec_imm  = '0;
    if (mode_is_legal(order[31:27])) begin
      dec_mode = order[31:27];
      dec_rw   = mode_has_rw(order[31:27]) & order[26];
      dec_sub  = order[25:24];
      dec_x1ch = (order[31:27] == MODE_STACK) ? IDX_W'(REG_SP) : IDX_W'(order[23:20]);
      dec_x2ch = IDX_W'(order[19:16]);
      dec_imm  = order[15:0];
    end
  end

  // Destination selection: y1 names the written register, y2 the side-effect target.
  always_comb begin
    dec_y1 = '0;
    dec_y2 = Y2_NONE;
    if (mode_is_alu(dec_mode) || (dec_mode == MODE_MOVE) || (dec_mode == MODE_XFER)) begin
      dec_y1 = dec_x1ch;
    end else if (((dec_mode == MODE_LOAD) || (dec_mode == MODE_STACK)) && dec_rw) begin
      dec_y1 = dec_x2ch;
    end else if (dec_mode == MODE_CJMP) begin
      dec_y1 = IDX_W'(REG_TPC);
    end
    if (mode_is_alu(dec_mode) || (dec_mode == MODE_TEST)) begin
      dec_y2 = Y2_FLAG;
    end else if (dec_mode == MODE_STACK) begin
      dec_y2 = Y2_SP;
    end
  end

  order_operand_sel #(
    .DATA_W   (DATA_W),
    .REG_CNT  (REG_CNT),
    .IDX_W    (IDX_W),
    .FWD_PORTS(FWD_PORTS)
  ) u_x1_sel (
    .ch_i       (dec_x1ch),
    .rf_flat_i  (rf_flat),
    .busy_i     (busy_q),
    .fwd_valid_i(fwd_valid),
    .fwd_idx_i  (fwd_idx),
    .fwd_data_i (fwd_data),
    .data_o     (x1_src),
    .hazard_o   (x1_haz)
  );

  order_operand_sel #(
    .DATA_W   (DATA_W),
    .REG_CNT  (REG_CNT),
    .IDX_W    (IDX_W),
    .FWD_PORTS(FWD_PORTS)
  ) u_x2_sel (
    .ch_i       (dec_x2ch),
    .rf_flat_i  (rf_flat),
    .busy_i     (busy_q),
    .fwd_valid_i(fwd_valid),
    .fwd_idx_i  (fwd_idx),
    .fwd_data_i (fwd_data),
    .data_o     (x2_src),
    .hazard_o   (x2_haz)
  );

  assign stall    = x1_haz | x2_haz;
  assign in_ready = !rst && !flush && !stall && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Output bundle register: load on accept, hold under back-pressure, drop valid on drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      mode_q      <= '0;
      rw_q        <= 1'b0;
      sub_q       <= '0;
      x1_q        <= '0;
      x2_q        <= '0;
      y1_q        <= '0;
      y2_q        <= '0;
      addr_q      <= '0;
      irq_q       <= 1'b0;
      irq_num_q   <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      mode_q      <= dec_mode;
      rw_q        <= dec_rw;
      sub_q       <= dec_sub;
      x1_q        <= x1_src;
      x2_q        <= (dec_x2ch == '0) ? DATA_W'(dec_imm) : x2_src;
      y1_q        <= dec_y1;
      y2_q        <= dec_y2;
      addr_q      <= in_addr;
      irq_q       <= in_irq;
      irq_num_q   <= in_irq_num;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Scoreboard update: retire first, then mark the new writer so a same-index set wins.
  always_comb begin
    busy_d = busy_q;
    if (wb_valid) begin
      busy_d[wb_idx] = 1'b0;
    end
    if (accept && (dec_y1 != '0)) begin
      busy_d[dec_y1] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Scoreboard register; reset and flush both forget every pending writer.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign mode        = mode_q;
  assign rw          = rw_q;
  assign sub_mode    = sub_q;
  assign x1          = x1_q;
  assign x2          = x2_q;
  assign y1_sel      = y1_q;
  assign y2_sel      = y2_q;
  assign out_addr    = addr_q;
  assign out_irq     = irq_q;
  assign out_irq_num = irq_num_q;

endmodule

// File: tb/tb_order_decode_pipe.sv
// Testbench for order_decode_pipe: directed scenarios plus a randomized run,
// all compared against a cycle-level behavioural model of the stage.
module tb_order_decode_pipe;

  localparam int DW = 32;
  localparam int RC = 16;
  localparam int IW = 4;
  localparam int FP = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       order;
  logic [DW-1:0]     in_addr;
  logic              in_irq;
  logic [7:0]        in_irq_num;
  logic [RC*DW-1:0]  rf_flat;
  logic [FP-1:0]     fwd_valid;
  logic [FP*IW-1:0]  fwd_idx;
  logic [FP*DW-1:0]  fwd_data;
  logic              wb_valid;
  logic [IW-1:0]     wb_idx;
  logic              out_valid;
  logic              out_ready;
  logic [4:0]        mode;
  logic              rw;
  logic [1:0]        sub_mode;
  logic [DW-1:0]     x1;
  logic [DW-1:0]     x2;
  logic [IW-1:0]     y1_sel;
  logic [1:0]        y2_sel;
  logic [DW-1:0]     out_addr;
  logic              out_irq;
  logic [7:0]        out_irq_num;

  logic [31:0] rf [RC];

  typedef struct packed {
    logic [4:0]  mode;
    logic        rw;
    logic [1:0]  sub;
    logic [31:0] x1;
    logic [31:0] x2;
    logic [3:0]  y1;
    logic [1:0]  y2;
    logic [31:0] addr;
    logic        irq;
    logic [7:0]  irq_num;
  } bundle_t;

  bundle_t     obs_b;
  bundle_t     exp_b;
  logic        exp_ov;
  logic [15:0] mb;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  // Pack the bench's register array into the flat bus the stage reads.
  always_comb begin
    for (int i = 0; i < RC; i++) rf_flat[i*DW +: DW] = rf[i];
  end

  assign obs_b = {mode, rw, sub_mode, x1, x2, y1_sel, y2_sel, out_addr, out_irq, out_irq_num};

  order_decode_pipe #(.DATA_W(DW), .REG_CNT(RC), .IDX_W(IW), .FWD_PORTS(FP)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .order(order), .in_addr(in_addr), .in_irq(in_irq), .in_irq_num(in_irq_num),
    .rf_flat(rf_flat), .fwd_valid(fwd_valid), .fwd_idx(fwd_idx), .fwd_data(fwd_data),
    .wb_valid(wb_valid), .wb_idx(wb_idx), .out_valid(out_valid), .out_ready(out_ready),
    .mode(mode), .rw(rw), .sub_mode(sub_mode), .x1(x1), .x2(x2), .y1_sel(y1_sel),
    .y2_sel(y2_sel), .out_addr(out_addr), .out_irq(out_irq), .out_irq_num(out_irq_num)
  );

  function automatic logic [31:0] mk(input int m, input bit w, input int sb, input int c1,
                                     input int c2, input int imm);
    return {5'(m), w, 2'(sb), 4'(c1), 4'(c2), 16'(imm)};
  endfunction

  // Does any forwarding port currently carry register c?
  function automatic bit ref_hit(input logic [3:0] c);
    for (int p = 0; p < FP; p++)
      if (fwd_valid[p] && fwd_idx[p*IW +: IW] == c) return 1'b1;
    return 1'b0;
  endfunction

  // Newest value of register c: first matching port, otherwise the register file.
  function automatic logic [31:0] ref_src(input logic [3:0] c);
    for (int p = 0; p < FP; p++)
      if (fwd_valid[p] && fwd_idx[p*IW +: IW] == c) return fwd_data[p*DW +: DW];
    return rf[c];
  endfunction

  // Bundle the current order should produce, plus the register channels it reads.
  function automatic bundle_t ref_decode(output logic [3:0] c1, output logic [3:0] c2);
    bundle_t b;
    int      m;
    bit      legal;
    m        = int'(order[31:27]);
    legal    = (m >= 1 && m <= 10) || m == 17 || m == 18;
    b        = '0;
    b.addr   = in_addr;
    b.irq    = in_irq;
    b.irq_num = in_irq_num;
    c1 = 4'd0;
    c2 = 4'd0;
    if (!legal) return b;
    c1     = (m == 8) ? 4'd13 : order[23:20];
    c2     = order[19:16];
    b.mode = 5'(m);
    b.rw   = (m <= 10) ? order[26] : 1'b0;
    b.sub  = order[25:24];
    b.x1   = (c1 == 0) ? 32'd0 : ref_src(c1);
    b.x2   = (c2 == 0) ? {16'd0, order[15:0]} : ref_src(c2);
    if ((m >= 1 && m <= 6) || m == 9 || m == 18) b.y1 = c1;
    else if ((m == 7 || m == 8) && b.rw)        b.y1 = c2;
    else if (m == 10)                           b.y1 = 4'd11;
    if ((m >= 1 && m <= 6) || m == 17) b.y2 = 2'd1;
    else if (m == 8)                   b.y2 = 2'd2;
    return b;
  endfunction

  function automatic logic model_ready();
    bundle_t     b;
    logic [3:0]  c1, c2;
    bit          st;
    b  = ref_decode(c1, c2);
    st = (c1 != 0 && mb[c1] && !ref_hit(c1)) || (c2 != 0 && mb[c2] && !ref_hit(c2));
    return !rst && !flush && !st && (!exp_ov || out_ready);
  endfunction

  // Advance the model by one cycle from the current inputs, then let the DUT clock.
  task automatic tick();
    bundle_t    nb;
    logic [3:0] c1, c2;
    logic       acc;
    nb  = ref_decode(c1, c2);
    acc = in_valid && model_ready();
    if (rst) begin
      exp_ov = 1'b0;
      exp_b  = '0;
      mb     = '0;
    end else if (flush) begin
      exp_ov = 1'b0;
      mb     = '0;
    end else begin
      if (wb_valid) mb[wb_idx] = 1'b0;
      if (acc) begin
        exp_b  = nb;
        exp_ov = 1'b1;
        if (nb.y1 != 0) mb[nb.y1] = 1'b1;
      end else if (out_ready) begin
        exp_ov = 1'b0;
      end
      mb[0] = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    in_valid  = 1'b0;
    order     = '0;
    fwd_valid = '0;
    wb_valid  = 1'b0;
    out_ready = 1'b1;
    flush     = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; order = '0; in_addr = '0; in_irq = 1'b0;
    in_irq_num = '0; fwd_valid = '0; fwd_idx = '0; fwd_data = '0; wb_valid = 1'b0;
    wb_idx = '0; out_ready = 1'b1; exp_ov = 1'b0; exp_b = '0; mb = '0;
    for (int i = 0; i < RC; i++) rf[i] = $urandom;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready: got %b want 0", in_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b0 || obs_b !== '0) begin
      errors++; $display("[TB] FAIL reset_outputs: got valid=%b bundle=%h want 0/0", out_valid, obs_b);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    rf[2] = 32'd5; order = mk(1, 0, 0, 2, 0, 'h1234); in_addr = 32'h0000_4000;
    in_irq = 1'b1; in_irq_num = 8'h5A; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_ready: got %b want 1", in_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b1 || x1 !== 32'd5 || x2 !== 32'h1234 || y1_sel !== 4'd2 || y2_sel !== 2'd1) begin
      errors++;
      $display("[TB] FAIL basic_bundle: got v=%b x1=%h x2=%h y1=%0d y2=%0d want 1 5 1234 2 1",
               out_valid, x1, x2, y1_sel, y2_sel);
    end
    checks++;
    if (obs_b !== exp_b || out_addr !== 32'h4000 || out_irq_num !== 8'h5A) begin
      errors++; $display("[TB] FAIL basic_model: got %h want %h", obs_b, exp_b);
    end
    settle();
  endtask

  task automatic test_stack_nop();
    rf[13] = 32'hDEAD_0013; rf[4] = 32'h0000_4444;
    order = mk(8, 1, 2, 0, 4, 0); in_valid = 1'b1;
    tick();
    checks++;
    if (mode !== 5'd8 || x1 !== 32'hDEAD_0013 || y1_sel !== 4'd4 || y2_sel !== 2'd2 || x2 !== 32'h4444) begin
      errors++;
      $display("[TB] FAIL stack_bundle: got mode=%0d x1=%h x2=%h y1=%0d y2=%0d want 8 dead0013 4444 4 2",
               mode, x1, x2, y1_sel, y2_sel);
    end
    order = mk(11, 1, 3, 5, 6, 'hFFFF);
    tick();
    checks++;
    if (out_valid !== 1'b1 || {mode, rw, sub_mode, y1_sel, y2_sel} !== '0 || x1 !== '0 || x2 !== '0) begin
      errors++;
      $display("[TB] FAIL nop_bundle: got v=%b mode=%0d rw=%b sub=%0d x1=%h x2=%h y1=%0d y2=%0d want NOP",
               out_valid, mode, rw, sub_mode, x1, x2, y1_sel, y2_sel);
    end
    checks++;
    if (obs_b !== exp_b) begin errors++; $display("[TB] FAIL nop_model: got %h want %h", obs_b, exp_b); end
    settle();
  endtask

  task automatic test_raw_hazard();
    rf[3] = 32'h3333_0003;
    order = mk(1, 0, 0, 3, 0, 1); in_valid = 1'b1;
    tick();
    order = mk(17, 0, 0, 3, 0, 7);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL raw_stall0: got %b want 0", in_ready); end
    tick();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL raw_stall1: got ready=%b valid=%b want 0 0", in_ready, out_valid);
    end
    wb_valid = 1'b1; wb_idx = 4'd3;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL raw_wb_cycle: got %b want 0", in_ready); end
    tick();
    wb_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL raw_release: got %b want 1", in_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b1 || x1 !== 32'h3333_0003) begin
      errors++; $display("[TB] FAIL raw_read: got v=%b x1=%h want 1 33330003", out_valid, x1);
    end
    order = mk(1, 0, 0, 3, 0, 1);
    tick();
    order = mk(17, 0, 0, 3, 0, 7);
    fwd_valid = 2'b10; fwd_idx = {4'd3, 4'd0}; fwd_data = {32'hAA, 32'h0};
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL fwd_ready: got %b want 1", in_ready); end
    tick();
    checks++;
    if (x1 !== 32'hAA || obs_b !== exp_b) begin
      errors++; $display("[TB] FAIL fwd_value: got x1=%h want aa (bundle %h want %h)", x1, obs_b, exp_b);
    end
    settle();
  endtask

  task automatic test_fwd_priority();
    order = mk(17, 0, 0, 3, 0, 0); in_valid = 1'b1;
    fwd_valid = 2'b11; fwd_idx = {4'd3, 4'd3}; fwd_data = {32'h22, 32'h11};
    tick();
    checks++;
    if (x1 !== 32'h11) begin errors++; $display("[TB] FAIL fwd_priority: got %h want 11", x1); end
    settle();
  endtask

  task automatic test_backpressure();
    order = mk(2, 0, 1, 1, 0, 'hAB); in_valid = 1'b1; out_ready = 1'b1;
    tick();
    out_ready = 1'b0; order = mk(17, 0, 0, 5, 6, 0); in_addr = 32'h0000_7777;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL hold_ready%0d: got %b want 0", i, in_ready); end
      tick();
      checks++;
      if (out_valid !== 1'b1 || mode !== 5'd2 || x1 !== rf[1] || x2 !== 32'hAB || obs_b !== exp_b) begin
        errors++;
        $display("[TB] FAIL hold_stable%0d: got v=%b mode=%0d x1=%h x2=%h want 1 2 %h ab",
                 i, out_valid, mode, x1, x2, rf[1]);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL hold_release: got %b want 1", in_ready); end
    tick();
    checks++;
    if (mode !== 5'd17 || obs_b !== exp_b) begin
      errors++; $display("[TB] FAIL hold_next: got mode=%0d bundle=%h want 17 %h", mode, obs_b, exp_b);
    end
    settle();
  endtask

  task automatic test_flush();
    order = mk(1, 0, 0, 5, 0, 1); in_valid = 1'b1; out_ready = 1'b1;
    tick();
    out_ready = 1'b0; order = mk(17, 0, 0, 5, 0, 0);
    flush = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_ready: got %b want 0", in_ready); end
    tick();
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_valid: got %b want 0", out_valid); end
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_busy: got ready=%b want 1", in_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b1 || x1 !== rf[5]) begin
      errors++; $display("[TB] FAIL flush_reader: got v=%b x1=%h want 1 %h", out_valid, x1, rf[5]);
    end
    settle();
  endtask

  task automatic test_reset_mid_stall();
    order = mk(1, 0, 0, 7, 0, 0); in_valid = 1'b1; out_ready = 1'b1;
    tick();
    out_ready = 1'b0; order = mk(17, 0, 0, 7, 0, 0);
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || obs_b !== '0) begin
      errors++; $display("[TB] FAIL rst_stall: got v=%b bundle=%h want 0 0", out_valid, obs_b);
    end
    rst = 1'b0; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_busy_clear: got %b want 1", in_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b1 || obs_b !== exp_b) begin
      errors++; $display("[TB] FAIL rst_reader: got %h want %h", obs_b, exp_b);
    end
    settle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      order      = mk($urandom_range(0, 20), 1'($urandom), $urandom_range(0, 3),
                      $urandom_range(0, 7), $urandom_range(0, 7), $urandom);
      in_valid   = ($urandom_range(0, 9) < 7);
      out_ready  = ($urandom_range(0, 3) != 0);
      in_addr    = $urandom;
      in_irq     = 1'($urandom);
      in_irq_num = 8'($urandom);
      fwd_valid  = {($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 3)};
      fwd_idx    = {4'($urandom_range(0, 7)), 4'($urandom_range(0, 7))};
      fwd_data   = {32'($urandom), 32'($urandom)};
      wb_valid   = ($urandom_range(0, 9) < 4);
      wb_idx     = 4'($urandom_range(0, 7));
      flush      = ($urandom_range(0, 99) < 3);
      rst        = ($urandom_range(0, 99) < 1);
      if ($urandom_range(0, 3) == 0) rf[$urandom_range(1, 15)] = $urandom;
      #1;
      checks++;
      if (in_ready !== model_ready()) begin
        errors++; $display("[TB] FAIL rand_ready[%0d]: got %b want %b", n, in_ready, model_ready());
      end
      tick();
      checks++;
      if (out_valid !== exp_ov || obs_b !== exp_b) begin
        errors++;
        $display("[TB] FAIL rand_bundle[%0d]: got v=%b %h want v=%b %h", n, out_valid, obs_b, exp_ov, exp_b);
      end
    end
    rst = 1'b0;
    settle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stack_nop();
    test_raw_hazard();
    test_fwd_priority();
    test_backpressure();
    test_flush();
    test_reset_mid_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
